// File: rtl/anubis_pkg.sv
// Shared ANUBIS definitions: round count, key type, GF(2^8) doubling and the
// key-schedule buffer state encoding.
package anubis_pkg;

  localparam int ANUBIS_ROUNDS = 12;

  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    LOAD,
    EMIT,
    HOLD
  } state_t;

  // Multiply by x (0x02) in GF(2^8) with reduction polynomial 0x11D
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

endpackage

// File: rtl/anubis_theta.sv
// ANUBIS theta: purely combinational 128-bit linear diffusion layer.
// The state is a 4x4 byte matrix, row i holds bytes 4i..4i+3 (byte 0 = MSB).
// Each row is multiplied by the involutional Hadamard matrix with h = {01,02,04,06}.
module anubis_theta
  import anubis_pkg::*;
(
  input  key_t state_in,
  output key_t state_out
);

  // Multiply a byte by h[sel]; 06 is formed as 04 ^ 02
  function automatic logic [7:0] mul_h(input logic [7:0] a, input logic [1:0] sel);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    case (sel)
      2'd0:    return a;
      2'd1:    return x2;
      2'd2:    return x4;
      default: return x4 ^ x2;
    endcase
  endfunction

  logic [7:0] acc;

  // Row-by-row matrix product b[i][j] = XOR_k a[i][k] * h[k^j]
  always_comb begin
    state_out = '0;
    acc       = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ mul_h(state_in[127 - 8 * (4 * i + k) -: 8], 2'(k ^ j));
        end
        state_out[127 - 8 * (4 * i + j) -: 8] = acc;
      end
    end
  end

endmodule

// File: rtl/anubis_dec_key_sched.sv
// Reverse-order round-key buffer for ANUBIS decryption.
// Captures K^0..K^R and replays K'^0 = K^R, K'^r = theta(K^(R-r)), K'^R = K^0.
// Optional feature macro: ANUBIS_DKEY_REUSE_EN adds a HOLD state from which the
// held schedule can be replayed for multi-block decryption under one key.
//
// state | meaning
// LOAD  | accepting encryption round keys into the buffer, K^0 first
// EMIT  | presenting decryption round keys K'^0..K'^R in order
// HOLD  | schedule retained; waiting for replay or a new key load
module anubis_dec_key_sched
  import anubis_pkg::*;
#(
  parameter int ROUNDS = ANUBIS_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic [127:0] key_in,
  input  logic         key_in_valid,
  output logic         key_in_ready,
  output logic [127:0] dkey_out,
  output logic [3:0]   dkey_idx,
  output logic         dkey_valid,
  input  logic         dkey_ready,
  input  logic         replay
);

  localparam logic [3:0] LAST = 4'(ROUNDS);

  key_t       key_mem_q [0:ROUNDS];
  state_t     state_q, state_d;
  logic [3:0] wr_idx_q, wr_idx_d;
  logic [3:0] rd_idx_q, rd_idx_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;

  logic       in_xfer;
  logic       out_xfer;
  logic [3:0] rd_ptr;
  key_t       rd_key;
  key_t       rd_key_theta;

  assign in_xfer  = clk_en & key_in_valid & ready_q;
  assign out_xfer = clk_en & dkey_ready & valid_q;

`ifndef ANUBIS_DKEY_REUSE_EN
  logic replay_unused;
  assign replay_unused = replay;
`endif

  // Key storage; intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (rst_n && in_xfer) begin
      key_mem_q[wr_idx_q] <= key_in;
    end
  end

  // Read path: reverse order, theta on every key except the first and last
  assign rd_ptr = LAST - rd_idx_q;
  assign rd_key = key_mem_q[rd_ptr];

  anubis_theta u_theta (
    .state_in  (rd_key),
    .state_out (rd_key_theta)
  );

  assign dkey_out     = (rd_idx_q == 4'd0 || rd_idx_q == LAST) ? rd_key : rd_key_theta;
  assign dkey_idx     = rd_idx_q;
  assign key_in_ready = clk_en & ready_q;
  assign dkey_valid   = clk_en & valid_q;

  // Next-state, counter and handshake-output decode
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    case (state_q)
      LOAD: begin
        if (in_xfer) begin
          if (wr_idx_q == LAST) begin
            state_d  = EMIT;
            wr_idx_d = 4'd0;
            rd_idx_d = 4'd0;
            ready_d  = 1'b0;
            valid_d  = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + 4'd1;
          end
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (rd_idx_q == LAST) begin
            rd_idx_d = 4'd0;
            valid_d  = 1'b0;
`ifdef ANUBIS_DKEY_REUSE_EN
            state_d  = HOLD;
            ready_d  = 1'b0;
`else
            state_d  = LOAD;
            ready_d  = 1'b1;
`endif
          end else begin
            rd_idx_d = rd_idx_q + 4'd1;
          end
        end
      end
`ifdef ANUBIS_DKEY_REUSE_EN
      HOLD: begin
        if (clk_en && replay) begin
          state_d  = EMIT;
          rd_idx_d = 4'd0;
          valid_d  = 1'b1;
        end else if (clk_en && key_in_valid) begin
          // The waking key is dropped; the source re-presents it once ready rises
          state_d  = LOAD;
          wr_idx_d = 4'd0;
          ready_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = LOAD;
        wr_idx_d = 4'd0;
        rd_idx_d = 4'd0;
        ready_d  = 1'b1;
        valid_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset wins over the clock enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      wr_idx_q <= 4'd0;
      rd_idx_q <= 4'd0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_anubis_dec_key_sched.sv
// Self-checking bench for anubis_dec_key_sched, with a reference model of the
// decryption key schedule built from GF(2^8) arithmetic. Honors ANUBIS_DKEY_REUSE_EN.
module tb_anubis_dec_key_sched;
  import anubis_pkg::*;

  localparam int R = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clk_en;
  logic [127:0] key_in;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [127:0] dkey_out;
  logic [3:0]   dkey_idx;
  logic         dkey_valid;
  logic         dkey_ready;
  logic         replay;

  key_t th_in;
  key_t th_out;

  int checks   = 0;
  int failures = 0;

  key_t keys [0:R];

  always #5 clk = ~clk;

  anubis_dec_key_sched #(.ROUNDS(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .key_in       (key_in),
    .key_in_valid (key_in_valid),
    .key_in_ready (key_in_ready),
    .dkey_out     (dkey_out),
    .dkey_idx     (dkey_idx),
    .dkey_valid   (dkey_valid),
    .dkey_ready   (dkey_ready),
    .replay       (replay)
  );

  anubis_theta u_theta_unit (
    .state_in  (th_in),
    .state_out (th_out)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [8:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = {1'b0, a_in};
    b = b_in;
    p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a[7:0];
      a = a << 1;
      if (a[8]) a = a ^ 9'h11D;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic key_t theta_ref(input key_t x);
    logic [7:0] h [0:3];
    logic [7:0] m [0:3][0:3];
    logic [7:0] v;
    key_t y;
    h[0] = 8'h01; h[1] = 8'h02; h[2] = 8'h04; h[3] = 8'h06;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = x[127 - 8 * (4 * i + j) -: 8];
    y = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        v = 8'h00;
        for (int k = 0; k < 4; k++) v = v ^ gf_mul(m[i][k], h[k ^ j]);
        y[127 - 8 * (4 * i + j) -: 8] = v;
      end
    return y;
  endfunction

  function automatic key_t exp_dkey(input int r);
    if (r == 0) return keys[R];
    if (r == R) return keys[0];
    return theta_ref(keys[R - r]);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Three cycles with the clock enable low; both handshakes must read 0
  task automatic gap();
    clk_en = 1'b0;
    repeat (3) begin
      #1;
      chk("gap_ready", key_in_ready, 0);
      chk("gap_valid", dkey_valid, 0);
      @(posedge clk);
      #1;
    end
    clk_en = 1'b1;
  endtask

  task automatic load_keys(input bit rnd, input int gate_at);
    int idx = 0;
    int budget = 0;
    bit gated = 0;
    while (idx <= R && budget < 400) begin
      if (idx == gate_at && !gated) begin
        gated = 1;
        key_in_valid = 1'b1;
        gap();
      end
      key_in       = keys[idx];
      key_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (key_in_valid && key_in_ready) idx++;
      step();
      budget++;
    end
    key_in_valid = 1'b0;
    chk("load_count", idx, R + 1);
    chk("latency_valid", dkey_valid, 1);
    chk("emit_ready_low", key_in_ready, 0);
  endtask

  task automatic drain(input int n, input bit rnd, input int gate_at);
    int cnt = 0;
    int budget = 0;
    bit gated = 0;
    while (cnt < n && budget < 400) begin
      if (cnt == gate_at && !gated) begin
        gated = 1;
        gap();
      end
      dkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("emit_valid", dkey_valid, 1);
      chk("emit_idx", dkey_idx, cnt);
      chk("emit_key", dkey_out, exp_dkey(cnt));
      chk("emit_in_ready", key_in_ready, 0);
      if (dkey_ready) cnt++;
      step();
      budget++;
    end
    dkey_ready = 1'b0;
    chk("drain_count", cnt, n);
  endtask

  task automatic to_load();
`ifdef ANUBIS_DKEY_REUSE_EN
    key_in       = 128'($urandom);
    key_in_valid = 1'b1;
    step();
    key_in_valid = 1'b0;
    chk("hold_wake_ready", key_in_ready, 1);
`endif
  endtask

  task automatic rand_keys();
    for (int i = 0; i <= R; i++)
      keys[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst_n        = 1'b0;
    clk_en       = 1'b1;
    key_in       = '0;
    key_in_valid = 1'b0;
    dkey_ready   = 1'b0;
    replay       = 1'b0;
    th_in        = '0;

    // Theta unit vectors
    th_in = {8'h01, 120'h0};
    #1 chk("theta_01", th_out, {32'h01020406, 96'h0});
    th_in = {8'h80, 120'h0};
    #1 chk("theta_80", th_out, {32'h801D3A27, 96'h0});
    th_in = {16{8'hA5}};
    #1 chk("theta_a5", th_out, {16{8'hA5}});

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", key_in_ready, 1);
    chk("rst_valid", dkey_valid, 0);
    chk("rst_idx", dkey_idx, 0);

    // Full schedule with known keys
    for (int i = 0; i <= R; i++) keys[i] = {8'(i), 120'h0};
    load_keys(0, -1);
    chk("idx0_const", dkey_out, {8'h0C, 120'h0});
    drain(R + 1, 0, -1);
    chk("post_emit_valid", dkey_valid, 0);
`ifdef ANUBIS_DKEY_REUSE_EN
    chk("hold_ready", key_in_ready, 0);
    replay = 1'b1;
    step();
    replay = 1'b0;
    drain(R + 1, 1, -1);
    chk("hold_again_valid", dkey_valid, 0);
    to_load();
`else
    chk("post_emit_ready", key_in_ready, 1);
    replay = 1'b1;
    step();
    chk("replay_ignored_valid", dkey_valid, 0);
    chk("replay_ignored_ready", key_in_ready, 1);
    replay = 1'b0;
`endif

    // Random keys with input and output backpressure
    rand_keys();
    load_keys(1, -1);
    drain(R + 1, 1, -1);
    to_load();

    // Clock-enable gaps mid-load and mid-emit
    rand_keys();
    load_keys(0, 5);
    drain(R + 1, 0, 6);
    to_load();

    // Reset after the 5th output transfer, then a fresh load
    rand_keys();
    load_keys(1, -1);
    drain(5, 0, -1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_ready", key_in_ready, 1);
    chk("midrst_valid", dkey_valid, 0);
    chk("midrst_idx", dkey_idx, 0);
    rand_keys();
    load_keys(0, -1);
    drain(R + 1, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
